// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory arbiter:
//     mode_t         : the eight load/store access codes seen on mode0/mode1
//     state_t        : arbiter sequencer states
//     is_store()     : 1 for SB/SH/SW, 0 for every load code
//     access_size()  : bytes touched by an access (1, 2 or 4)
//     is_misaligned(): half-word on an odd address, word not on a 4-byte one
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [2:0] {
    MODE_LB  = 3'b000,
    MODE_LH  = 3'b001,
    MODE_LW  = 3'b010,
    MODE_LBU = 3'b011,
    MODE_LHU = 3'b100,
    MODE_SB  = 3'b101,
    MODE_SH  = 3'b110,
    MODE_SW  = 3'b111
  } mode_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  function automatic logic is_store(input logic [2:0] mode);
    logic store;
    case (mode_t'(mode))
      MODE_SB, MODE_SH, MODE_SW: store = 1'b1;
      default:                   store = 1'b0;
    endcase
    return store;
  endfunction

  function automatic logic [2:0] access_size(input logic [2:0] mode);
    logic [2:0] size;
    case (mode_t'(mode))
      MODE_LH, MODE_LHU, MODE_SH: size = 3'd2;
      MODE_LW, MODE_SW:           size = 3'd4;
      default:                    size = 3'd1;
    endcase
    return size;
  endfunction

  // Only the two low address bits matter for alignment.
  function automatic logic is_misaligned(input logic [2:0] mode,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (mode_t'(mode))
      MODE_LH, MODE_LHU, MODE_SH: bad = addr_lo[0];
      MODE_LW, MODE_SW:           bad = (addr_lo != 2'b00);
      default:                    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Two-input round-robin arbiter. A lone requester wins outright; on a tie
//   the port that was not granted most recently wins. The last-grant flop
//   moves on every cycle where update is high and a grant was issued.
//
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-low; last-grant pointer -> 1 so port 0
//              wins the first tie
//     req    : per-port request (already qualified by the caller)
//     update : advance the last-grant pointer with this cycle's grant
//     gnt    : one-hot grant, combinational
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_reg;
  logic last_next;

  // Port gi wins if it requests and either the other port is idle or the
  // other port was the one granted last time.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last_reg != 1'(gi)));
    end
  endgenerate

  // gnt is one-hot, so gnt[1] is the index of the winner.
  always_comb begin
    last_next = last_reg;
    if (update && (gnt != 2'b00)) begin
      last_next = gnt[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// data_mem_arbiter
//   Arbitrates the core load/store port (port 0) and the loader/debug port
//   (port 1) onto the single data memory. One request is granted per IDLE
//   cycle; alignment and range are checked before the memory is touched.
//   Stores and rejected accesses complete in one cycle, loads take two
//   because the memory's read data is registered.
//
//   Ports:
//     clk, reset         : clock and synchronous active-low reset
//     req[1:0]           : per-port request, held until granted
//     mode0/1, addr0/1,
//     wdata0/1           : per-port access code, byte address and store data
//     gnt[1:0]           : one-hot grant, combinational (request consumed)
//     rsp_valid[1:0]     : registered one-cycle response pulse to the owner
//     rsp_err            : access was misaligned or out of range
//     rsp_rdata          : load data (0 for stores and errors)
//     mem_addr/wdata/mode,
//     mem_write/mem_read : memory controls
//     mem_rdata          : memory read data, valid the cycle after mem_read
// -----------------------------------------------------------------------------
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int Width     = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [2:0]       mode0,
  input  logic [2:0]       mode1,
  input  logic [Width-1:0] addr0,
  input  logic [Width-1:0] addr1,
  input  logic [Width-1:0] wdata0,
  input  logic [Width-1:0] wdata1,
  output logic [1:0]       gnt,
  output logic [1:0]       rsp_valid,
  output logic             rsp_err,
  output logic [Width-1:0] rsp_rdata,
  output logic [Width-1:0] mem_addr,
  output logic [Width-1:0] mem_wdata,
  output logic [2:0]       mem_mode,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [Width-1:0] mem_rdata
);

  state_t           state_reg,     state_next;
  logic             owner_reg,     owner_next;
  logic [1:0]       rsp_valid_reg, rsp_valid_next;
  logic             rsp_err_reg,   rsp_err_next;
  logic [Width-1:0] rsp_rdata_reg, rsp_rdata_next;

  logic [1:0]       arb_req;
  logic [1:0]       arb_gnt;
  logic             granted;
  logic             win;
  logic [2:0]       sel_mode;
  logic [Width-1:0] sel_addr;
  logic [Width-1:0] sel_wdata;
  logic [Width:0]   end_addr;
  logic             out_of_range;
  logic             acc_err;
  logic             acc_store;

  // ---------------------------------------------------------------------------
  // Arbitration. Requests are only visible to the arbiter in IDLE and out of
  // reset, so anything raised during RD_WAIT simply waits for the next IDLE.
  // ---------------------------------------------------------------------------
  assign arb_req = ((state_reg == ST_IDLE) && reset) ? req : 2'b00;

  rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (arb_req),
    .update (granted),
    .gnt    (arb_gnt)
  );

  assign granted = (arb_gnt != 2'b00);
  assign win     = arb_gnt[1];

  // ---------------------------------------------------------------------------
  // Request mux and access check for the winning port.
  // ---------------------------------------------------------------------------
  assign sel_mode  = win ? mode1  : mode0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  // One extra bit so an address near the top of the space cannot wrap and
  // slip past the range check.
  assign end_addr     = {1'b0, sel_addr} + (Width+1)'(access_size(sel_mode));
  assign out_of_range = (end_addr > (Width+1)'(MEM_BYTES));
  assign acc_err      = out_of_range | is_misaligned(sel_mode, sel_addr[1:0]);
  assign acc_store    = is_store(sel_mode);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= 1'b0;
      rsp_valid_reg <= 2'b00;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic, including the response registers and the load owner.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rsp_valid_next = 2'b00;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    case (state_reg)
      ST_IDLE: begin
        if (granted) begin
          if (acc_err) begin
            rsp_valid_next = win ? 2'b10 : 2'b01;
            rsp_err_next   = 1'b1;
          end else if (acc_store) begin
            rsp_valid_next = win ? 2'b10 : 2'b01;
          end else begin
            // Load: remember who asked, the data shows up next cycle.
            owner_next = win;
            state_next = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        rsp_valid_next = owner_reg ? 2'b10 : 2'b01;
        rsp_rdata_next = mem_rdata;
        state_next     = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. The memory bus carries the winner's payload only in a grant
  // cycle; a rejected access still shows its address but never strobes.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt       = arb_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_mode  = 3'b000;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (granted) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      mem_mode  = sel_mode;
      mem_write = ~acc_err & acc_store;
      mem_read  = ~acc_err & ~acc_store;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_mem_arbiter
//   Directed, table-driven bench for data_mem_arbiter with a 64-byte
//   little-endian memory model (registered read, mode-aware extraction).
//   Each table row is one clock cycle: inputs applied after the rising edge,
//   outputs compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam logic [2:0] M_LB  = 3'b000;
  localparam logic [2:0] M_LH  = 3'b001;
  localparam logic [2:0] M_LW  = 3'b010;
  localparam logic [2:0] M_LBU = 3'b011;
  localparam logic [2:0] M_LHU = 3'b100;
  localparam logic [2:0] M_SB  = 3'b101;
  localparam logic [2:0] M_SW  = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [2:0]  mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_mode;
  logic        mem_write, mem_read;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.Width(32), .MEM_BYTES(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .mode0     (mode0),
    .mode1     (mode1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_mode  (mem_mode),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem [64];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  end

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return (a < 32'd64) ? mem[a[5:0]] : 8'h00;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] m, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = rd_byte(a);
    b1 = rd_byte(a + 32'd1);
    b2 = rd_byte(a + 32'd2);
    b3 = rd_byte(a + 32'd3);
    case (m)
      M_LB:    return {{24{b0[7]}}, b0};
      M_LBU:   return {24'h0, b0};
      M_LH:    return {{16{b1[7]}}, b1, b0};
      M_LHU:   return {16'h0, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_write) begin
      for (int k = 0; k < 4; k++) begin
        if ((k == 0 || (k < 2 && mem_mode != M_SB) || mem_mode == M_SW) &&
            (mem_addr + 32'(k) < 32'd64)) begin
          mem[6'(mem_addr + 32'(k))] <= mem_wdata[8*k +: 8];
        end
      end
    end
    if (mem_read) begin
      mem_rdata <= load_val(mem_mode, mem_addr);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [2:0]  m0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [2:0]  m1;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [1:0]  e_gnt;
    logic        e_mw;
    logic        e_mr;
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;
    logic [2:0]  e_mmode;
    logic [1:0]  e_rv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    reset  = v.rst;
    req    = v.req;
    mode0  = v.m0;
    addr0  = v.a0;
    wdata0 = v.d0;
    mode1  = v.m1;
    addr1  = v.a1;
    wdata1 = v.d1;
    @(negedge clk);
    n_checks++;
    if ({gnt, mem_write, mem_read, mem_addr, mem_wdata, mem_mode, rsp_valid, rsp_err, rsp_rdata} !==
        {v.e_gnt, v.e_mw, v.e_mr, v.e_maddr, v.e_mwdata, v.e_mmode, v.e_rv, v.e_err, v.e_rdata}) begin
      n_errors++;
      $display("FAIL vec%0d: got gnt=%b mw=%b mr=%b addr=%h wd=%h mode=%0d rv=%b err=%b rd=%h; expected gnt=%b mw=%b mr=%b addr=%h wd=%h mode=%0d rv=%b err=%b rd=%h",
               idx, gnt, mem_write, mem_read, mem_addr, mem_wdata, mem_mode, rsp_valid, rsp_err, rsp_rdata,
               v.e_gnt, v.e_mw, v.e_mr, v.e_maddr, v.e_mwdata, v.e_mmode, v.e_rv, v.e_err, v.e_rdata);
    end else begin
      $display("vec%0d ok: req=%b gnt=%b rv=%b err=%b rd=%h", idx, v.req, gnt, rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] q,
                       input logic [2:0] m0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic [2:0] m1, input logic [31:0] a1, input logic [31:0] d1);
    reset = r; req = q;
    mode0 = m0; addr0 = a0; wdata0 = d0;
    mode1 = m1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    //          rst req   m0     a0      d0            m1     a1      d1         gnt   mw mr  maddr   mwdata        mmode  rv    err rdata
    // Port 0 store then load-back
    vecs[0]  = '{1'b1, 2'b01, M_SW,  32'h08, 32'hDEADBEEF, M_LB, 32'h00, 32'h00, 2'b01, 1'b1, 1'b0, 32'h08, 32'hDEADBEEF, M_SW,  2'b00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'b01, M_LW,  32'h08, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h08, 32'h0,        M_LW,  2'b01, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 2'b00, M_LW,  32'h08, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 2'b00, M_LW,  32'h08, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b01, 1'b0, 32'hDEADBEEF};
    // Reset cycle, then both ports SB continuously: 01,10,01,10
    vecs[4]  = '{1'b0, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 2'b11, M_SB,  32'h20, 32'h11,       M_SB, 32'h21, 32'h22, 2'b01, 1'b1, 1'b0, 32'h20, 32'h11,       M_SB,  2'b00, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'b11, M_SB,  32'h20, 32'h11,       M_SB, 32'h21, 32'h22, 2'b10, 1'b1, 1'b0, 32'h21, 32'h22,       M_SB,  2'b01, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 2'b11, M_SB,  32'h20, 32'h11,       M_SB, 32'h21, 32'h22, 2'b01, 1'b1, 1'b0, 32'h20, 32'h11,       M_SB,  2'b10, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 2'b11, M_SB,  32'h20, 32'h11,       M_SB, 32'h21, 32'h22, 2'b10, 1'b1, 1'b0, 32'h21, 32'h22,       M_SB,  2'b01, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b10, 1'b0, 32'h0};
    // Errors: port 0 SW 0x3E (range), port 1 LH 0x3 (misaligned)
    vecs[10] = '{1'b1, 2'b11, M_SW,  32'h3E, 32'hCAFE0001, M_LH, 32'h03, 32'h00, 2'b01, 1'b0, 1'b0, 32'h3E, 32'hCAFE0001, M_SW,  2'b00, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 2'b10, M_SW,  32'h3E, 32'hCAFE0001, M_LH, 32'h03, 32'h00, 2'b10, 1'b0, 1'b0, 32'h03, 32'h0,        M_LH,  2'b01, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b10, 1'b1, 32'h0};
    // Range boundary: SB 0x3F ok, SB 0x40 error, LW 0x3C ok
    vecs[13] = '{1'b1, 2'b01, M_SB,  32'h3F, 32'hAB,       M_LB, 32'h00, 32'h00, 2'b01, 1'b1, 1'b0, 32'h3F, 32'hAB,       M_SB,  2'b00, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 2'b01, M_SB,  32'h40, 32'hCD,       M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b0, 32'h40, 32'hCD,       M_SB,  2'b01, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 2'b01, M_LW,  32'h3C, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h3C, 32'h0,        M_LW,  2'b01, 1'b1, 32'h0};
    vecs[16] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b01, 1'b0, 32'hAB000000};
    // Port 1 raises req during port 0's RD_WAIT: granted in T+2
    vecs[18] = '{1'b1, 2'b01, M_LW,  32'h08, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h08, 32'h0,        M_LW,  2'b00, 1'b0, 32'h0};
    vecs[19] = '{1'b1, 2'b10, M_LB,  32'h00, 32'h0,        M_SW, 32'h10, 32'h12345678, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,  M_LB,  2'b00, 1'b0, 32'h0};
    vecs[20] = '{1'b1, 2'b10, M_LB,  32'h00, 32'h0,        M_SW, 32'h10, 32'h12345678, 2'b10, 1'b1, 1'b0, 32'h10, 32'h12345678, M_SW, 2'b01, 1'b0, 32'hDEADBEEF};
    vecs[21] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b10, 1'b0, 32'h0};
    // Byte/half loads after SW 0x80FF7F81 at 0x0
    vecs[22] = '{1'b1, 2'b01, M_SW,  32'h00, 32'h80FF7F81, M_LB, 32'h00, 32'h00, 2'b01, 1'b1, 1'b0, 32'h00, 32'h80FF7F81, M_SW,  2'b00, 1'b0, 32'h0};
    vecs[23] = '{1'b1, 2'b01, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h00, 32'h0,        M_LB,  2'b01, 1'b0, 32'h0};
    vecs[24] = '{1'b1, 2'b01, M_LBU, 32'h01, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[25] = '{1'b1, 2'b01, M_LBU, 32'h01, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h01, 32'h0,        M_LBU, 2'b01, 1'b0, 32'hFFFFFF81};
    vecs[26] = '{1'b1, 2'b01, M_LH,  32'h02, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[27] = '{1'b1, 2'b01, M_LH,  32'h02, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h02, 32'h0,        M_LH,  2'b01, 1'b0, 32'h0000007F};
    vecs[28] = '{1'b1, 2'b01, M_LHU, 32'h02, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[29] = '{1'b1, 2'b01, M_LHU, 32'h02, 32'h0,        M_LB, 32'h00, 32'h00, 2'b01, 1'b0, 1'b1, 32'h02, 32'h0,        M_LHU, 2'b01, 1'b0, 32'hFFFF80FF};
    vecs[30] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b00, 1'b0, 32'h0};
    vecs[31] = '{1'b1, 2'b00, M_LB,  32'h00, 32'h0,        M_LB, 32'h00, 32'h00, 2'b00, 1'b0, 1'b0, 32'h00, 32'h0,        M_LB,  2'b01, 1'b0, 32'h000080FF};

    // Reset held low with both ports requesting: nothing may be granted.
    drive(1'b0, 2'b11, M_SW, 32'h04, 32'h1, M_SW, 32'h08, 32'h2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_state", {56'h0, gnt, mem_write, mem_read, rsp_valid, rsp_err, rsp_err},
                       64'h0);
    chk("reset_rdata", {32'h0, rsp_rdata}, 64'h0);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Reset during RD_WAIT of a port 0 LBU: the load is dropped, and the
    // pointer (last granted port 0 before reset) returns to favouring port 0.
    drive(1'b1, 2'b01, M_LBU, 32'h10, 32'h0, M_LB, 32'h0, 32'h0);
    @(negedge clk);
    chk("lbu_grant", {60'h0, gnt, mem_read, mem_write}, {60'h0, 2'b01, 1'b1, 1'b0});
    $display("seq lbu grant: gnt=%b mr=%b", gnt, mem_read);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, M_LB, 32'h0, 32'h0, M_LB, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst_in_rdwait", {60'h0, gnt, rsp_valid}, 64'h0);
    $display("seq reset in RD_WAIT: gnt=%b rv=%b", gnt, rsp_valid);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {62'h0, rsp_valid}, 64'h0);
      $display("seq post-reset cycle %0d: rv=%b", c, rsp_valid);
      @(posedge clk); #1;
    end
    drive(1'b1, 2'b11, M_SB, 32'h30, 32'h5A, M_SB, 32'h31, 32'hA5);
    @(negedge clk);
    chk("tie_after_rst", {62'h0, gnt}, {62'h0, 2'b01});
    $display("seq first tie after reset: gnt=%b", gnt);
    @(posedge clk); #1;
    req = 2'b10;
    @(negedge clk);
    chk("second_after_rst", {60'h0, gnt, rsp_valid}, {60'h0, 2'b10, 2'b01});
    $display("seq second grant: gnt=%b rv=%b", gnt, rsp_valid);
    @(posedge clk); #1;
    req = 2'b00;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared byte-addressed data memory.
  - Port 0: core load/store path.
  - Port 1: program loader / debug access.
- Selects one request per cycle using round-robin. Checks alignment and range before touching memory.
- Drives the memory's Address/W_Data/Mode/MemWrite/MemRead controls and returns a registered response to the winning requester.
- Sits between the core datapath and the data memory in the single-cycle processor top level.

Parameters:
- Width, 32, data and address width.
- MEM_BYTES, 64, memory size in bytes. Addresses at or above this value are errors.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 resets.
- req  input  2  per-port request; bit i belongs to port i.
- mode0, mode1  input  3  access mode. 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
- addr0, addr1  input  Width  byte address.
- wdata0, wdata1  input  Width  store data.
- gnt  output  2  one-hot, combinational; the request is consumed at this edge.
- rsp_valid  output  2  one-hot, registered, 1-cycle response pulse.
- rsp_err  output  1  valid with rsp_valid; 1 = misaligned or out-of-range access.
- rsp_rdata  output  Width  load data; 0 for stores and errors.
- mem_addr  output  Width  to memory Address.
- mem_wdata  output  Width  to memory W_Data.
- mem_mode  output  3  to memory Mode.
- mem_write  output  1  to memory MemWrite.
- mem_read  output  1  to memory MemRead.
- mem_rdata  input  Width  from memory R_Data; registered inside memory, valid the cycle after mem_read.

Behaviour:
- Store: mode is 101..111. Every other mode is a load.
- Error conditions:
  - SH/LH/LHU with addr[0]=1.
  - SW/LW with addr[1:0]!=0.
  - addr + size > MEM_BYTES, where size is 1, 2 or 4.
- FSM states: IDLE, RD_WAIT.
- IDLE, no req: gnt=0, mem_write=0, mem_read=0. mem_addr/mem_wdata/mem_mode = 0.
- IDLE, req!=0: the arbiter picks winner w.
  - gnt[w]=1 in the same cycle T.
  - mem_addr, mem_wdata and mem_mode are muxed from port w.
- Arbitration:
  - Single requester wins outright.
  - With both requesting, the port not granted most recently wins.
  - The last-grant pointer updates on every grant, including error grants.
  - Reset value of the pointer = 1, so port 0 wins the first tie.
- Granted store, no error: mem_write=1 in T. rsp_valid[w]=1, rsp_err=0, rsp_rdata=0 in T+1. State stays IDLE, so a new grant is possible in T+1.
- Granted load, no error:
  - mem_read=1 in T; next state RD_WAIT.
  - In T+1 (RD_WAIT): gnt=0, mem_read=0, mem_write=0. mem_rdata is captured at the end of T+1.
  - In T+2: rsp_valid[w]=1, rsp_rdata=captured data, rsp_err=0. State is IDLE again and may grant in T+2.
- Granted error: mem_write=0 and mem_read=0 in T. Memory is untouched. rsp_valid[w]=1, rsp_err=1, rsp_rdata=0 in T+1. State stays IDLE.
- mem_write and mem_read are never both 1.
- Load throughput: 1 per 2 cycles. Store/error throughput: 1 per cycle.
- Requester protocol:
  - Hold req and payload stable until gnt.
  - After gnt, may present the next request immediately; it is arbitrated in the next IDLE cycle.
  - Deasserting req before gnt withdraws the request; no response follows.
- The owner of an in-flight load is held in a register. req from either port during RD_WAIT waits; it is not lost and not granted.
- Reset (reset=0 at an edge):
  - State -> IDLE, pointer -> 1.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - The pending load owner is cleared.
  - A load in RD_WAIT is discarded and produces no response.
  - gnt=0, mem_write=0 and mem_read=0 while reset is low.

Decomposition:
- Package dmem_pkg holds:
  - mode_t enum with the eight codes above.
  - function is_store(mode).
  - function access_size(mode), returning 1, 2 or 4.
  - function is_misaligned(mode, addr).
- Sub-module rr_arb2: 2-input round-robin arbiter.
  - Inputs: req[1:0], update-enable.
  - Output: one-hot gnt.
  - Holds the last-grant flop and reset logic.
- Top level holds the FSM, request mux, error check and response registers.

Test Plan:
- Port 0 SW addr=0x8 wdata=0xDEADBEEF, then LW addr=0x8 -> mem_write=1 for 1 cycle. Store rsp_valid[0] at T+1. Load rsp_valid[0] at T+2 with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Both ports request SB continuously from reset -> gnt sequence 01,10,01,10. Each port receives rsp_valid one cycle after its gnt.
- Port 1 LH addr=0x3 and port 0 SW addr=0x3E -> rsp_err=1, rsp_rdata=0 on each. mem_write/mem_read never assert.
- Port 0 LW in flight while port 1 raises req in RD_WAIT -> gnt[1] asserts first in T+2, not T+1. Port 0 response is still delivered in T+2.
- reset=0 during RD_WAIT of an LBU addr=0x10 -> no rsp_valid. After release, the first tie goes to port 0.
- Byte/half loads after SW 0x80FF7F81 at 0x0 -> LB 0x0 = 0xFFFFFF81, LBU 0x1 = 0x0000007F, LH 0x2 = 0xFFFF80FF, LHU 0x2 = 0x000080FF.
